// File: rtl/accel_smoothing_pkg.sv
// accel_smoothing_pkg
//   Shared definitions for the accelerometer smoothing block: default sample
//   width, default averaging window, the signed sample type, and the helper
//   that sizes the running-sum accumulator.
package accel_smoothing_pkg;

  localparam int DATA_W = 16;
  localparam int LOG2_N = 3;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Width of a running sum that can hold 2**log2n full-scale samples without
  // overflow: one extra bit per doubling of the window.
  function automatic int sum_w(input int log2n, input int data_w = DATA_W);
    return data_w + log2n;
  endfunction

endpackage

// File: rtl/moving_avg.sv
// moving_avg
//   One axis of the smoothing filter: an N-entry circular sample buffer with
//   a running sum, N = 2**LOG2_N. Each enabled cycle replaces the oldest
//   sample with the new one and adjusts the sum by the difference, so the
//   average costs one add/subtract per sample regardless of N.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous active-high reset; clears buffer, sum, pointer
//   en     in   sample strobe; one sample consumed per cycle it is high
//   din    in   signed input sample
//   avg    out  sum >>> LOG2_N (floor), combinational from the registered sum
//   last   out  most recently accepted sample
module moving_avg
  import accel_smoothing_pkg::*;
#(
  parameter int DATA_W = accel_smoothing_pkg::DATA_W,
  parameter int LOG2_N = accel_smoothing_pkg::LOG2_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] avg,
  output logic signed [DATA_W-1:0] last
);

  localparam int N     = 1 << LOG2_N;
  localparam int SUM_W = sum_w(LOG2_N, DATA_W);

  if (LOG2_N < 1 || LOG2_N > 6) begin : g_bad_window
    $error("moving_avg: LOG2_N must be in 1..6");
  end

  logic signed [DATA_W-1:0] smp_buf [N];
  logic        [LOG2_N-1:0] ptr_p0;
  logic signed [SUM_W-1:0]  sum_p0;
  logic signed [DATA_W-1:0] last_p0;

  logic signed [DATA_W-1:0] oldest;
  logic signed [SUM_W-1:0]  din_ext;
  logic signed [SUM_W-1:0]  old_ext;
  logic signed [SUM_W-1:0]  sum_next;

  // The slot under the pointer holds the sample that falls out of the window.
  assign oldest   = smp_buf[ptr_p0];
  assign din_ext  = {{LOG2_N{din[DATA_W-1]}}, din};
  assign old_ext  = {{LOG2_N{oldest[DATA_W-1]}}, oldest};
  assign sum_next = sum_p0 + din_ext - old_ext;

  // Stage p0: buffer write, pointer advance, running sum, last sample.
  // The pointer is exactly LOG2_N bits wide, so it wraps N-1 -> 0 by itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) smp_buf[i] <= '0;
      ptr_p0  <= '0;
      sum_p0  <= '0;
      last_p0 <= '0;
    end else if (en) begin
      smp_buf[ptr_p0] <= din;
      ptr_p0          <= ptr_p0 + 1'b1;
      sum_p0          <= sum_next;
      last_p0         <= din;
    end
  end

  // Dropping the low LOG2_N bits of a two's-complement sum is an arithmetic
  // shift that floors toward -inf. The sum of N in-range samples divided by
  // N is always in range, so the remaining DATA_W bits never wrap.
  assign avg  = sum_p0[SUM_W-1:LOG2_N];
  assign last = last_p0;

endmodule

// File: rtl/accel_smoothing.sv
// accel_smoothing
//   Per-axis moving-average filter between the accelerometer sample interface
//   and the video overlay. Samples stream in on data_update; the displayed
//   values are only reloaded on a rising edge of v_sync so they stay constant
//   for a whole frame. SW[0]/SW[1] choose smoothed or raw per axis.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   SW[9:0]      in   SW[0] X smoothing enable, SW[1] Y smoothing enable,
//                     SW[9:2] unused
//   data_x       in   signed X sample
//   data_y       in   signed Y sample
//   data_update  in   sample-valid, one sample pair per high cycle
//   v_sync       in   frame sync, asynchronous to clk, rising edge used
//   out_x        out  signed X output, frame-stable
//   out_y        out  signed Y output, frame-stable
module accel_smoothing
  import accel_smoothing_pkg::*;
#(
  parameter int DATA_W = accel_smoothing_pkg::DATA_W,
  parameter int LOG2_N = accel_smoothing_pkg::LOG2_N
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               SW,
  input  logic signed [DATA_W-1:0] data_x,
  input  logic signed [DATA_W-1:0] data_y,
  input  logic                     data_update,
  input  logic                     v_sync,
  output logic signed [DATA_W-1:0] out_x,
  output logic signed [DATA_W-1:0] out_y
);

  logic signed [DATA_W-1:0] avg_x;
  logic signed [DATA_W-1:0] avg_y;
  logic signed [DATA_W-1:0] last_x;
  logic signed [DATA_W-1:0] last_y;

  logic vsync_p0;
  logic vsync_p1;
  logic vsync_p2;
  logic frame_edge;

  logic unused_sw;
  assign unused_sw = ^SW[9:2];

  moving_avg #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_avg_x (
    .clk   (clk),
    .reset (reset),
    .en    (data_update),
    .din   (data_x),
    .avg   (avg_x),
    .last  (last_x)
  );

  moving_avg #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_avg_y (
    .clk   (clk),
    .reset (reset),
    .en    (data_update),
    .din   (data_y),
    .avg   (avg_y),
    .last  (last_y)
  );

  // Stages p0/p1: two-flop synchronizer for the asynchronous v_sync.
  // Stage p2: history flop for rising-edge detection. Because p2 clears on
  // reset, a v_sync already high at reset release still yields one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_p0 <= 1'b0;
      vsync_p1 <= 1'b0;
      vsync_p2 <= 1'b0;
    end else begin
      vsync_p0 <= v_sync;
      vsync_p1 <= vsync_p0;
      vsync_p2 <= vsync_p1;
    end
  end

  assign frame_edge = vsync_p1 & ~vsync_p2;

  // Output stage: reload once per frame. avg/last are read from the filter's
  // registers, so a sample accepted on the same edge is not yet visible here.
  // SW is quasi-static and sampled directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_x <= '0;
      out_y <= '0;
    end else if (frame_edge) begin
      out_x <= SW[0] ? avg_x : last_x;
      out_y <= SW[1] ? avg_y : last_y;
    end
  end

endmodule

// File: tb/tb_accel_smoothing.sv
module tb_accel_smoothing;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [9:0]         SW;
  logic signed [15:0] data_x;
  logic signed [15:0] data_y;
  logic               data_update;
  logic               v_sync;
  logic signed [15:0] out_x;
  logic signed [15:0] out_y;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  accel_smoothing dut (
    .clk         (clk),
    .reset       (reset),
    .SW          (SW),
    .data_x      (data_x),
    .data_y      (data_y),
    .data_update (data_update),
    .v_sync      (v_sync),
    .out_x       (out_x),
    .out_y       (out_y)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    data_update = 1'b0;
    v_sync = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Exactly n posedges see data_update high with the given pair.
  task automatic push_n(input int x, input int y, input int n);
    @(negedge clk);
    data_x = 16'(x);
    data_y = 16'(y);
    data_update = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    data_update = 1'b0;
  endtask

  // Raise v_sync, confirm nothing moves before the third edge, then check.
  task automatic rise_check(input string tag, input int ex, input int ey);
    int px, py;
    px = out_x;
    py = out_y;
    @(negedge clk);
    v_sync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_early_x"}, out_x, px);
    check({tag, "_early_y"}, out_y, py);
    @(posedge clk);
    #1;
    check({tag, "_x"}, out_x, ex);
    check({tag, "_y"}, out_y, ey);
    @(negedge clk);
    v_sync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int prev_x;
    int changes;
    SW = {8'b0, 2'b11};
    data_x = 16'sd1234;
    data_y = -16'sd77;
    data_update = 1'b1;
    v_sync = 1'b1;

    // Reset with busy inputs: outputs clear immediately and stay cleared.
    #2 reset = 1'b1;
    #1;
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_held_x", out_x, 0);
    check("rst_held_y", out_y, 0);
    @(negedge clk);
    data_update = 1'b0;
    v_sync = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rise_check("nosample", 0, 0);

    // Steady state, then frame stability while new samples arrive.
    push_n(100, 100, 10);
    rise_check("steady", 100, 100);
    push_n(200, 200, 5);
    repeat (10) @(negedge clk);
    check("steady_hold_x", out_x, 100);
    check("steady_hold_y", out_y, 100);

    // Step response: 1/8 of the step after one sample, full after eight.
    do_reset();
    push_n(800, -16, 1);
    rise_check("step1", 100, -2);
    push_n(800, -16, 7);
    rise_check("step8", 800, -16);

    // Floor rounding: 7/8 -> 0, -1/8 -> -1.
    do_reset();
    push_n(7, -1, 1);
    rise_check("floor", 0, -1);

    // Full-scale extremes do not wrap.
    do_reset();
    push_n(32767, -32768, 8);
    rise_check("extreme", 32767, -32768);

    // Bypass X, smooth Y; upper switches are don't-care.
    do_reset();
    SW = {8'bx, 2'b10};
    for (int i = 0; i < 8; i++) push_n(i * 8, i * 8, 1);
    rise_check("bypass", 56, 28);

    // Asynchronous reset between clock edges clears nonzero outputs.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_x", out_x, 0);
    check("async_rst_y", out_y, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Sample coinciding with the output-load edge is not yet visible:
    // X smoothed, Y raw, both must show the value before the 800 sample.
    SW = {8'b0, 2'b01};
    push_n(40, 40, 8);
    @(negedge clk);
    v_sync = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    data_x = 16'sd800;
    data_y = 16'sd800;
    data_update = 1'b1;
    @(posedge clk);
    #1;
    check("same_cycle_x", out_x, 40);
    check("same_cycle_y", out_y, 40);
    @(negedge clk);
    data_update = 1'b0;
    v_sync = 1'b0;
    repeat (4) @(negedge clk);

    // Frame gating: ramp every cycle, v_sync rises at iterations 10/30/50,
    // outputs may only change at iterations 13/33/53.
    do_reset();
    SW = {8'b0, 2'b11};
    prev_x = out_x;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      check($sformatf("gate_c%0d", c), int'(out_x != 16'(prev_x)),
            int'(c == 13 || c == 33 || c == 53));
      prev_x = out_x;
      data_x = 16'(200 + c * 8);
      data_y = 16'(c);
      data_update = 1'b1;
      v_sync = ((c / 10) % 2) == 1;
    end
    @(negedge clk);
    data_update = 1'b0;
    v_sync = 1'b0;

    // v_sync held high for over 100 cycles: exactly one update.
    do_reset();
    changes = 0;
    prev_x = out_x;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (out_x != 16'(prev_x)) changes++;
      prev_x = out_x;
      data_x = 16'(100 + c * 8);
      data_y = 16'(c);
      data_update = 1'b1;
      v_sync = (c >= 10);
    end
    check("hold_high_updates", changes, 1);
    @(negedge clk);
    data_update = 1'b0;
    v_sync = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
